// File: rtl/item_scan_reader_if.sv
// Draw-request handshake between item_scan_reader (master) and the sprite renderer (slave).
interface item_scan_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_index;
    logic [8:0] req_left;
    logic [7:0] req_top;
    logic [1:0] req_kind;
    logic       req_visible;
    logic       req_moved;

    modport master (
        output req_valid, req_index, req_left, req_top, req_kind, req_visible, req_moved,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_index, req_left, req_top, req_kind, req_visible, req_moved,
        output req_ready
    );
endinterface

// File: rtl/item_scan_reader.sv
// Walks the packed item list once per start and emits one draw request per slot.
// Optional macro ITEM_SCAN_SKIP_HIDDEN_EN: slots with visible=0 are consumed without a request.
//
// state | meaning
// IDLE  | waiting for start; count latched on start
// FETCH | register slot idx into the request fields (or skip / finish)
// EMIT  | req_valid high, held until handshake
// DONE  | one-cycle done pulse, busy still high
module item_scan_reader #(
    parameter int MAX_ITEMS = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MAX_ITEMS*32-1:0] data,
    input  logic [5:0]             count,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    item_scan_reader_if.master     req
);

    localparam int         IDX_W   = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
    localparam logic [6:0] MAX_CNT = 7'(MAX_ITEMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } stateType;

    stateType   state;
    logic [5:0] idx;
    logic [6:0] cntQ;

    logic [31:0] slotWord [MAX_ITEMS];
    logic [31:0] slot;
    logic [12:0] xField;
    logic [11:0] yField;
    logic [1:0]  idxKind;
    logic [6:0]  cntClamped;
    logic        lastSlot;
    logic        unusedFieldBits;

    for (genvar n = 0; n < MAX_ITEMS; n++) begin : gSlot
        assign slotWord[n] = data[n*32 +: 32];
    end

    // idx never reaches cntQ, so the slot select stays inside the bus
    assign slot    = slotWord[idx[IDX_W-1:0]];
    assign xField  = slot[31:19];
    assign yField  = slot[18:7];
    assign idxKind = (idx[5:4] != 2'b00) ? 2'd2 : {1'b0, idx[3]};

    assign cntClamped = ({1'b0, count} > MAX_CNT) ? MAX_CNT : {1'b0, count};
    assign lastSlot   = ({1'b0, idx} == (cntQ - 7'd1));

    assign unusedFieldBits = ^{xField[3:0], yField[3:0], slot[6:2]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            cntQ            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            req.req_valid   <= 1'b0;
            req.req_index   <= '0;
            req.req_left    <= '0;
            req.req_top     <= '0;
            req.req_kind    <= '0;
            req.req_visible <= 1'b0;
            req.req_moved   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cntQ  <= cntClamped;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (cntQ == 7'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        req.req_index   <= idx;
                        req.req_left    <= xField[12:4];
                        req.req_top     <= yField[11:4];
                        req.req_kind    <= idxKind;
                        req.req_visible <= slot[1];
                        req.req_moved   <= slot[0];
`ifdef ITEM_SCAN_SKIP_HIDDEN_EN
                        if (!slot[1]) begin
                            if (lastSlot) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                idx <= idx + 6'd1;
                            end
                        end else begin
                            req.req_valid <= 1'b1;
                            state         <= EMIT;
                        end
`else
                        req.req_valid <= 1'b1;
                        state         <= EMIT;
`endif
                    end
                end

                EMIT: begin
                    if (req.req_ready) begin
                        req.req_valid <= 1'b0;
                        if (lastSlot) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= FETCH;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_item_scan_reader.sv
// Self-checking bench for item_scan_reader: queue-based request model plus directed scans.
module tb_item_scan_reader;

    localparam int MAX = 32;
`ifdef ITEM_SCAN_SKIP_HIDDEN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic [MAX*32-1:0]  data;
    logic [5:0]         count;
    logic               start;
    logic               busy;
    logic               done;

    item_scan_reader_if reqIf ();

    item_scan_reader #(.MAX_ITEMS(MAX)) dut (
        .clock (clock),
        .reset (reset),
        .data  (data),
        .count (count),
        .start (start),
        .busy  (busy),
        .done  (done),
        .req   (reqIf)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0] index;
        logic [8:0] left;
        logic [7:0] top;
        logic [1:0] kind;
        logic       visible;
        logic       moved;
    } req_t;

    req_t expQ [$];

    int nChecks = 0;
    int nFails  = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic req_t curReq();
        req_t r;
        r.index   = reqIf.req_index;
        r.left    = reqIf.req_left;
        r.top     = reqIf.req_top;
        r.kind    = reqIf.req_kind;
        r.visible = reqIf.req_visible;
        r.moved   = reqIf.req_moved;
        return r;
    endfunction

    // Spec-level decode of one slot
    function automatic req_t modelReq(input int i);
        req_t        r;
        logic [31:0] w;
        logic [12:0] x;
        logic [11:0] y;
        w = data[i*32 +: 32];
        x = w[31:19];
        y = w[18:7];
        r.index   = 6'(i);
        r.left    = 9'(x >> 4);
        r.top     = 8'(y >> 4);
        r.kind    = (i >= 16) ? 2'd2 : ((i >= 8) ? 2'd1 : 2'd0);
        r.visible = w[1];
        r.moved   = w[0];
        return r;
    endfunction

    task automatic buildExp(input int cnt);
        int   n;
        req_t r;
        expQ.delete();
        n = (cnt > MAX) ? MAX : cnt;
        for (int i = 0; i < n; i++) begin
            r = modelReq(i);
            if (!(SKIP && !r.visible)) expQ.push_back(r);
        end
    endtask

    task automatic setSlot(input int i, input logic [12:0] x, input logic [11:0] y,
                           input logic vis, input logic mov);
        data[i*32 +: 32] = {x, y, 5'b0, vis, mov};
    endtask

    task automatic fillPattern(input int n);
        data = '0;
        for (int i = 0; i < n; i++)
            setSlot(i, 13'(i*37 + 100), 12'(i*91 + 30), 1'b1, 1'(i & 1));
    endtask

    // Monitor state
    int         cyc = 0;
    bit         hsLast = 1'b0;
    bit         prevValid = 1'b0;
    req_t       prevReq;
    int         doneCount, doneCyc, firstValidCyc, handshakes, idx1Cycles;
    req_t       firstReq;
    int         seenCount [64];
    logic [1:0] kindSeen [64];
    int         stallIdx = -1;
    int         stallLeft = 0;

    task automatic clearStats();
        doneCount     = 0;
        doneCyc       = -1;
        firstValidCyc = -1;
        handshakes    = 0;
        idx1Cycles    = 0;
        firstReq      = '0;
        for (int i = 0; i < 64; i++) begin
            seenCount[i] = 0;
            kindSeen[i]  = 2'd3;
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        hsLast = 1'b0;
        if (!reset && reqIf.req_valid && reqIf.req_ready) begin
            hsLast = 1'b1;
            handshakes++;
            seenCount[reqIf.req_index]++;
            kindSeen[reqIf.req_index] = reqIf.req_kind;
            if (expQ.size() > 0) void'(expQ.pop_front());
        end
    end

    always @(negedge clock) begin
        req_t cur;
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            cur = curReq();
            if (prevValid && !hsLast) begin
                chk("valid_held", 64'(reqIf.req_valid), 64'd1);
                chk("req_stable", 64'(cur), 64'(prevReq));
            end
            if (reqIf.req_valid) begin
                if (firstValidCyc < 0) begin
                    firstValidCyc = cyc;
                    firstReq      = cur;
                end
                if (cur.index == 6'd1) idx1Cycles++;
                if (expQ.size() == 0) chk("unexpected_req", 64'(reqIf.req_valid), 64'd0);
                else                  chk("req_vs_model", 64'(cur), 64'(expQ[0]));
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
                chk("done_pending_reqs", 64'(expQ.size()), 64'd0);
                chk("busy_in_done", 64'(busy), 64'd1);
            end
            prevValid = reqIf.req_valid;
            prevReq   = cur;
        end
    end

    // Renderer: ready high except for a programmed stall on one index
    initial begin
        reqIf.req_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset && reqIf.req_valid && (int'(reqIf.req_index) == stallIdx) && stallLeft > 0) begin
                reqIf.req_ready = 1'b0;
                stallLeft--;
            end else begin
                reqIf.req_ready = 1'b1;
            end
        end
    end

    task automatic runScan(input int cnt, input int budget, output int tStart);
        int w;
        buildExp(cnt);
        clearStats();
        @(posedge clock); #1;
        count  = 6'(cnt);
        start  = 1'b1;
        tStart = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        w = 0;
        while (doneCount == 0 && w < budget) begin
            @(negedge clock);
            w++;
        end
        chk("done_seen", 64'(doneCount), 64'd1);
        @(posedge clock); #1;
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("queue_drained", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int w;
        int d0;

        reset = 1'b1;
        start = 1'b0;
        count = '0;
        data  = '0;
        clearStats();
        #12;
        chk("reset_outputs", 64'({busy, done, reqIf.req_valid, curReq()}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Single item
        data = '0;
        setSlot(0, 13'h0A0, 12'h050, 1'b1, 1'b0);
        runScan(1, 20, t);
        chk("single_first_valid_cyc", 64'(firstValidCyc), 64'(t + 2));
        chk("single_done_cyc", 64'(doneCyc), 64'(t + 3));
        chk("single_index", 64'(firstReq.index), 64'd0);
        chk("single_left", 64'(firstReq.left), 64'd10);
        chk("single_top", 64'(firstReq.top), 64'd5);
        chk("single_kind", 64'(firstReq.kind), 64'd0);
        chk("single_handshakes", 64'(handshakes), 64'd1);

        // Backpressure on slot 1
        fillPattern(3);
        stallIdx  = 1;
        stallLeft = 4;
        runScan(3, 100, t);
        chk("bp_idx1_cycles", 64'(idx1Cycles), 64'd5);
        chk("bp_stall_used", 64'(stallLeft), 64'd0);
        for (int i = 0; i < 3; i++) chk("bp_seen_once", 64'(seenCount[i]), 64'd1);
        chk("bp_done_count", 64'(doneCount), 64'd1);
        stallIdx = -1;

        // Kind boundaries
        fillPattern(17);
        runScan(17, 200, t);
        chk("kind_idx7", 64'(kindSeen[7]), 64'd0);
        chk("kind_idx8", 64'(kindSeen[8]), 64'd1);
        chk("kind_idx15", 64'(kindSeen[15]), 64'd1);
        chk("kind_idx16", 64'(kindSeen[16]), 64'd2);
        chk("kind_handshakes", 64'(handshakes), 64'd17);
        chk("kind_done_cyc", 64'(doneCyc), 64'(t + 35));

        // count = 0
        runScan(0, 20, t);
        chk("zero_no_valid", 64'(firstValidCyc), 64'(-1));
        chk("zero_done_cyc", 64'(doneCyc), 64'(t + 2));
        chk("zero_handshakes", 64'(handshakes), 64'd0);

        // count above MAX_ITEMS
        fillPattern(MAX);
        runScan(40, 400, t);
        chk("clamp_handshakes", 64'(handshakes), 64'd32);
        chk("clamp_last_seen", 64'(seenCount[31]), 64'd1);
        chk("clamp_done_cyc", 64'(doneCyc), 64'(t + 65));

        // Hidden slot 2
        fillPattern(4);
        setSlot(2, 13'h1234, 12'h567, 1'b0, 1'b1);
        runScan(4, 100, t);
        chk("hidden_handshakes", 64'(handshakes), SKIP ? 64'd3 : 64'd4);
        chk("hidden_idx2_seen", 64'(seenCount[2]), SKIP ? 64'd0 : 64'd1);
        chk("hidden_idx3_seen", 64'(seenCount[3]), 64'd1);
        chk("hidden_done_cyc", 64'(doneCyc), SKIP ? 64'(t + 8) : 64'(t + 9));

        // Reset during EMIT of slot 1
        fillPattern(3);
        buildExp(3);
        clearStats();
        stallIdx  = 1;
        stallLeft = 1000;
        @(posedge clock); #1;
        count = 6'd3;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        w = 0;
        while (!(reqIf.req_valid && reqIf.req_index == 6'd1) && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk("rst_reached_emit1", 64'(reqIf.req_valid && reqIf.req_index == 6'd1), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_outputs_zero", 64'({busy, done, reqIf.req_valid, curReq()}), 64'd0);
        expQ.delete();
        stallLeft = 0;
        stallIdx  = -1;
        d0 = doneCount;
        repeat (3) @(negedge clock);
        chk("rst_no_done", 64'(doneCount), 64'(d0));
        reset = 1'b0;
        runScan(3, 100, t);
        chk("rst_rescan_first_idx", 64'(firstReq.index), 64'd0);
        chk("rst_rescan_handshakes", 64'(handshakes), 64'd3);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
